// File: rtl/temporizador_param_pkg.sv
// temporizador_param_pkg: state encodings and mode constants shared by the timer files.
package temporizador_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } estado_t;

    localparam logic MODO_UNICO     = 1'b0;
    localparam logic MODO_PERIODICO = 1'b1;

endpackage

// File: rtl/temporizador_param_if.sv
// temporizador_param_if: control/status bundle between a control FSM (master) and the timer (slave).
interface temporizador_param_if #(parameter int W = 32);

    logic         Habilitar;
    logic         Iniciar;
    logic         Modo;
    logic         Pausa;
    logic [W-1:0] Limite;
    logic [W-1:0] Cuenta;
    logic         FinalCuenta;
    logic         PulsoFin;
    logic         Activo;

    modport master (
        output Habilitar, Iniciar, Modo, Pausa, Limite,
        input  Cuenta, FinalCuenta, PulsoFin, Activo
    );

    modport slave (
        input  Habilitar, Iniciar, Modo, Pausa, Limite,
        output Cuenta, FinalCuenta, PulsoFin, Activo
    );

endinterface

// File: rtl/temporizador_param_prescaler_tick.sv
// prescaler_tick: divides enabled clocks by PRESC; Tick is high on the last clock of each group.
module prescaler_tick #(
    parameter int PRESC = 1,
    parameter int PW    = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Clr,
    input  logic En,
    output logic Tick
);

    logic [PW-1:0] r_cnt;

    assign Tick = En && (r_cnt == PW'(PRESC - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_cnt <= '0;
        else if (Clr || Tick)
            r_cnt <= '0;
        else if (En)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/temporizador_param.sv
// temporizador_param: programmable one-shot/periodic tick timer with pause, restart and expiry pulse.
module temporizador_param
    import temporizador_param_pkg::*;
#(
    parameter int W     = 32,
    parameter int PRESC = 1,
    parameter int PW    = 16
) (
    input logic                Clk,
    input logic                Reset_n,
    temporizador_param_if.slave bus
);

    estado_t      r_state, w_nxt;
    logic [W-1:0] r_cuenta, w_cuenta;
    logic [W-1:0] r_lim, w_lim;
    logic         r_modo, w_modo;
    logic         r_final, w_final;
    logic         r_pulso, w_pulso;
    logic         r_activo;
    logic         w_tick;
    logic         w_periodico;

    prescaler_tick #(.PRESC(PRESC), .PW(PW)) u_presc (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Clr     (!bus.Habilitar || bus.Iniciar),
        .En      ((r_state == ST_RUN) && !bus.Pausa),
        .Tick    (w_tick)
    );

    assign w_periodico = (r_modo == MODO_PERIODICO);

    always_comb begin
        w_nxt    = r_state;
        w_cuenta = r_cuenta;
        w_lim    = r_lim;
        w_modo   = r_modo;
        w_final  = r_final;
        w_pulso  = 1'b0;
        if (!bus.Habilitar) begin
            w_nxt    = ST_IDLE;
            w_cuenta = '0;
            w_final  = 1'b0;
        end else if (bus.Iniciar) begin
            // A zero limit is treated as one tick so the count can still expire.
            w_lim    = (bus.Limite == '0) ? W'(1) : bus.Limite;
            w_modo   = bus.Modo;
            w_cuenta = '0;
            w_final  = 1'b0;
            w_nxt    = ST_RUN;
        end else if (w_tick) begin
            if (r_cuenta == r_lim - 1'b1) begin
                w_pulso  = 1'b1;
                w_cuenta = w_periodico ? '0 : r_lim;
                w_final  = !w_periodico;
                w_nxt    = w_periodico ? ST_RUN : ST_DONE;
            end else
                w_cuenta = r_cuenta + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_cuenta <= '0;
            r_lim    <= '0;
            r_modo   <= MODO_UNICO;
            r_final  <= 1'b0;
            r_pulso  <= 1'b0;
            r_activo <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_cuenta <= w_cuenta;
            r_lim    <= w_lim;
            r_modo   <= w_modo;
            r_final  <= w_final;
            r_pulso  <= w_pulso;
            r_activo <= (w_nxt == ST_RUN);
        end
    end

    assign bus.Cuenta      = r_cuenta;
    assign bus.FinalCuenta = r_final;
    assign bus.PulsoFin    = r_pulso;
    assign bus.Activo      = r_activo;

endmodule

// File: doc/temporizador_param.md
Name: temporizador_param

Overview:
Parametrised, programmable successor to the single fixed-count timer used in the control FSMs. It counts prescaled clock ticks up to a run-time limit. It supports one-shot and periodic modes, pause/resume and restart, and reports both a level "done" flag and a single-cycle expiry pulse. It sits beside the control FSMs, which drive Habilitar/Iniciar and consume FinalCuenta/PulsoFin.

Parameters:
W, 32, width of Limite and Cuenta.
PRESC, 1, clocks per count tick (>=1); 1 = count every clock.
PW, 16, width of internal prescaler counter (must hold PRESC-1).

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Habilitar  input  1  master enable; 0 = synchronous clear to idle.
Iniciar  input  1  start/restart strobe, sampled each edge.
Modo  input  1  0 = one-shot, 1 = periodic; latched at start.
Pausa  input  1  1 = freeze counting (RUN only).
Limite  input  W  terminal count; latched at start.
Cuenta  output  W  current tick count.
FinalCuenta  output  1  level: one-shot expired (held until cleared/restart).
PulsoFin  output  1  one-cycle pulse on every expiry.
Activo  output  1  1 while in RUN.

Behaviour:
- Reset (Reset_n=0, async): state=IDLE; Cuenta, prescaler, LimReg, ModoReg, FinalCuenta, PulsoFin, Activo all 0.
- All outputs are registered; PulsoFin defaults to 0 each cycle.
- States: IDLE, RUN, DONE.
- Priority per edge: Habilitar=0 > Iniciar > expiry > Pausa > count.
- Habilitar=0, any state: next state IDLE, Cuenta=0, prescaler=0, FinalCuenta=0, no pulse.
- Iniciar=1 with Habilitar=1, any state:
  - LimReg<=Limite, with 0 mapped to 1; ModoReg<=Modo.
  - Cuenta<=0, prescaler<=0, FinalCuenta<=0, state<=RUN.
  - This is a restart in RUN/DONE; a coincident expiry is discarded and no PulsoFin is raised.
- Tick: asserted when state=RUN, Pausa=0, and prescaler==PRESC-1.
  - Prescaler increments in RUN when Pausa=0 and wraps to 0 on tick.
- RUN, tick, Cuenta!=LimReg-1: Cuenta<=Cuenta+1.
- RUN, tick, Cuenta==LimReg-1 (expiry), PulsoFin<=1 and then:
  - ModoReg=0: Cuenta<=LimReg, FinalCuenta<=1, state<=DONE.
  - ModoReg=1: Cuenta<=0, stay RUN; FinalCuenta stays 0.
- Pausa=1 in RUN: Cuenta and prescaler hold; Activo stays 1; no expiry while paused.
- DONE: Cuenta holds LimReg, FinalCuenta=1, Activo=0. Leaves DONE only via Iniciar or Habilitar=0.
- IDLE: ignores Pausa/Modo/Limite until Iniciar.
- Activo=1 exactly when state=RUN.
- Latency with PRESC=1, Limite=N, Iniciar sampled at edge E0: PulsoFin high for the cycle after edge EN.
- General latency: N*PRESC cycles after start, plus any paused cycles.
- Limite changes after start have no effect until the next Iniciar.
- Cuenta never exceeds LimReg, so there is no wrap-around. Limite=2^W-1 is valid.
- Legacy equivalence: W=32, PRESC=1, Modo=0, Limite=30000000, Iniciar tied to the Habilitar rising edge.
- Reset_n asserted mid-count: immediate return to reset values; release is synchronised externally.

Decomposition:
- Shared include temporizador_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - MODO_UNICO=1'b0, MODO_PERIODICO=1'b1.
- One natural sub-module: prescaler_tick (params PRESC, PW; ports Clk, Reset_n, Clr, En, Tick), instantiated once.
- FSM and count register stay in the top module.

Test Plan:
- Reset_n=0 mid-RUN with Cuenta=5 -> all outputs 0 on the same cycle; IDLE after release.
- PRESC=1, Modo=0, Limite=4, Iniciar pulse at E0 -> Cuenta 1,2,3,4 after E1..E4; PulsoFin=1 only the cycle after E4; FinalCuenta stays 1 and Cuenta=4 for 10 further cycles.
- PRESC=3, Modo=1, Limite=2 -> PulsoFin every 6 cycles, three times; Cuenta sequence 0,0,0,1,1,1,0...; FinalCuenta=0 throughout.
- Limite=10, PRESC=1, Pausa=1 for 5 cycles starting at Cuenta=3 -> Cuenta holds 3; expiry delayed to 15 cycles after start; Activo stays 1.
- Iniciar reasserted on the same edge as expiry (Limite=3) -> no PulsoFin; Cuenta=0; new limit from Limite latched; FinalCuenta=0.
- Habilitar dropped in DONE, and separately with Iniciar=1 -> IDLE, Cuenta=0, FinalCuenta=0; Iniciar ignored while Habilitar=0. Limite=0 -> expires after 1 tick.
